// File: rtl/comb_scan_pkg.sv
// Shared types and constants for the combinational truth-table scanner.
package comb_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [15:0] DEF_EXP_MASK = 16'h0040;
  localparam logic [3:0]  VEC_LAST     = 4'd15;

endpackage

// File: rtl/comb_scan_ctrl_if.sv
// Control, stimulus and result signals between the scanner and its host.
interface comb_scan_ctrl_if;

  logic        start;
  logic        abort;
  logic        pause;
  logic        y_in;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] result;
  logic [4:0]  err_cnt;
  logic [3:0]  fail_idx;

  modport master (
    output start, abort, pause, y_in,
    input  A, B, C, D, busy, done, pass, result, err_cnt, fail_idx
  );

  modport slave (
    input  start, abort, pause, y_in,
    output A, B, C, D, busy, done, pass, result, err_cnt, fail_idx
  );

endinterface

// File: rtl/comb_scan_acc.sv
// Result accumulator: captured truth table, mismatch count and first failing index.
module comb_scan_acc
  import comb_scan_pkg::*;
#(
  parameter logic [15:0] EXP_MASK = DEF_EXP_MASK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        cap_i,
  input  logic [3:0]  vec_i,
  input  logic        y_i,
  output logic [15:0] result_o,
  output logic [4:0]  err_cnt_o,
  output logic [3:0]  fail_idx_o,
  output logic        err_zero_d_o
);

  logic [15:0] result_q, result_d;
  logic [4:0]  err_cnt_q, err_cnt_d;
  logic [3:0]  fail_idx_q, fail_idx_d;

  always_comb begin
    result_d   = result_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    if (clr_i) begin
      result_d   = '0;
      err_cnt_d  = '0;
      fail_idx_d = '0;
    end else if (cap_i) begin
      result_d[vec_i] = y_i;
      if (y_i != EXP_MASK[vec_i]) begin
        err_cnt_d = err_cnt_q + 5'd1;
        // only the lowest failing index is kept; vectors are scanned in ascending order
        if (err_cnt_q == 5'd0) fail_idx_d = vec_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
    end else begin
      result_q   <= result_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign result_o     = result_q;
  assign err_cnt_o    = err_cnt_q;
  assign fail_idx_o   = fail_idx_q;
  assign err_zero_d_o = (err_cnt_d == 5'd0);

endmodule

// File: rtl/comb_scan_ctrl.sv
// Scan controller: walks ABCD through 0..15, captures y_in and grades it against EXP_MASK.
//   state   | meaning
//   IDLE    | waiting for start, ABCD holds last vector
//   APPLY   | driving vec for SETTLE cycles
//   CAPTURE | sampling y_in for vec, then advance or finish
//   DONE    | one-cycle done pulse, pass valid
module comb_scan_ctrl
  import comb_scan_pkg::*;
#(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXP_MASK = DEF_EXP_MASK
) (
  input logic             clk,
  input logic             rst,
  comb_scan_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_TC = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       clr;
  logic       cap;
  logic       err_zero_d;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    clr      = 1'b0;
    cap      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = ST_APPLY;
          vec_d    = '0;
          settle_d = '0;
          clr      = 1'b1;
        end
      end
      ST_APPLY: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!bus.pause) begin
          if (settle_q == SETTLE_TC) begin
            state_d  = ST_CAPTURE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
      end
      ST_CAPTURE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!bus.pause) begin
          cap = 1'b1;
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_APPLY;
            vec_d   = vec_q + 4'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_APPLY) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
    pass_d = pass_q;
    if (clr || bus.abort) begin
      pass_d = 1'b0;
    end else if (cap && (vec_q == VEC_LAST)) begin
      pass_d = err_zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  comb_scan_acc #(
    .EXP_MASK (EXP_MASK)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .cap_i        (cap),
    .vec_i        (vec_q),
    .y_i          (bus.y_in),
    .result_o     (bus.result),
    .err_cnt_o    (bus.err_cnt),
    .fail_idx_o   (bus.fail_idx),
    .err_zero_d_o (err_zero_d)
  );

  assign {bus.A, bus.B, bus.C, bus.D} = vec_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;

endmodule
